fft_frame_tx: RTL
=================

Name: fft_frame_tx

Overview:
- AXI-Stream frame transmitter that feeds the FFT wrapper's config and input-sample channels.
- Host logic preloads one frame of N real samples into an internal register buffer and pulses start.
- The block then sends one config word, streams N samples with tlast on the final sample, and pulses done.
- It is the driving end of the wrapper's config and input AXIS channels. Used in the FFT bring-up datapath and as the bench stimulus source.

Parameters:
- DATA_W, 8, sample width (real part only; imaginary padding is done downstream).
- N_LOG2, 3, log2 of frame length N (N = 2**N_LOG2 = 8).
- CFG_W, 8, config word width.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  N_LOG2  buffer write address.
- wr_data  in  DATA_W  buffer write data.
- start  in  1  single-cycle frame launch request.
- cfg_word  in  CFG_W  config word, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last sample handshake.
- config_data  out  CFG_W  config channel tdata.
- config_valid  out  1  config channel tvalid.
- config_ready  in  1  config channel tready.
- tx_data  out  DATA_W  sample channel tdata.
- tx_valid  out  1  sample channel tvalid.
- tx_last  out  1  sample channel tlast.
- tx_ready  in  1  sample channel tready.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, config_valid, tx_valid, tx_last = 0; config_data, tx_data = 0; index = 0. Buffer contents are not reset.
- Buffer: N x DATA_W registers.
  - Written when wr_en=1 and busy=0.
  - Writes while busy=1 are dropped, so an in-flight frame is never corrupted.
- FSM states: IDLE, CFG, DATA, DONE.
- IDLE:
  - start=1 latches cfg_word into config_data, sets busy=1 and config_valid=1 on the next edge, then goes to CFG.
  - start while busy is ignored.
- CFG:
  - config_valid and config_data are held stable until config_ready=1.
  - On the handshake edge: config_valid<=0, tx_data<=buf[0], tx_valid<=1, tx_last<=(N==1), index<=0, then go to DATA.
- DATA:
  - A beat completes when tx_valid & tx_ready.
  - On a non-final beat: index<=index+1, tx_data<=buf[index+1], tx_last<=(index+1==N-1).
  - On the final beat (tx_last=1): tx_valid<=0, tx_last<=0, done<=1, then go to DONE.
  - tx_valid never drops without a handshake. tx_data and tx_last stay stable while tx_ready=0.
- DONE (one cycle): done<=0, busy<=0, then go to IDLE. A start arriving in the DONE cycle is ignored.
- Latency with always-ready sinks:
  - start at cycle 0 -> config_valid at cycle 1.
  - First sample valid at cycle 2.
  - Last sample at cycle N+1.
  - done high at cycle N+2.
  - busy low at cycle N+3.
- Index counter is N_LOG2 bits wide and never wraps within a frame; it resets to 0 on every config handshake.
- Reset mid-frame aborts the frame immediately: all outputs return to reset values and no done pulse is produced.
- Backpressure on either channel only stretches the sequence; order and data are unchanged.

Optional Feature:
- Macro: FFT_FRAME_TX_CNT_EN.
- Defined:
  - Adds output port frame_cnt [15:0], reset to 0.
  - Increments on the cycle done is asserted and wraps 16'hFFFF -> 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Load buf = 8'h10..8'h17, cfg_word = 8'h01, start, ready sinks held high -> config_data 8'h01 at cycle 1; tx_data 10..17 on cycles 2..9; tx_last only with 8'h17; done at cycle 10.
- config_ready held low 5 cycles -> config_valid and config_data stable for 5 cycles, no tx_valid; stream starts the cycle after config_ready rises.
- tx_ready toggled 1,0,0,1,... -> each sample held stable while ready=0; exactly 8 beats; output order 10..17 unchanged.
- Write wr_addr=3, wr_data=8'hAA while busy, then start a second frame -> second frame still carries 8'h13 at index 3.
- start pulsed during DATA and in the DONE cycle -> ignored; exactly one frame and one done pulse.
- Assert aresetn=0 after the 4th beat -> outputs zero within the reset assertion; a new start sends a full 8-sample frame.
- With FFT_FRAME_TX_CNT_EN defined, 3 back-to-back frames -> frame_cnt = 3.

Source files
------------

// File: rtl/fft_frame_tx_if.sv
// AXI-Stream config and sample channels between fft_frame_tx and the FFT wrapper.
// master drives tdata/tvalid(/tlast); slave returns tready.
interface fft_frame_tx_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CFG_W  = 8
);
    logic [CFG_W-1:0]  config_data;
    logic              config_valid;
    logic              config_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;

    modport master (
        output config_data, config_valid, tx_data, tx_valid, tx_last,
        input  config_ready, tx_ready
    );

    modport slave (
        input  config_data, config_valid, tx_data, tx_valid, tx_last,
        output config_ready, tx_ready
    );
endinterface

// File: rtl/fft_frame_tx.sv
// Frame transmitter: one config word, then N buffered samples with tlast, then a done pulse.
// Optional FFT_FRAME_TX_CNT_EN adds a 16-bit completed-frame counter output.
module fft_frame_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_LOG2 = 3,
    parameter int unsigned CFG_W  = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr_en,
    input  logic [N_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [CFG_W-1:0]  cfg_word,
    output logic              busy,
    output logic              done,
`ifdef FFT_FRAME_TX_CNT_EN
    output logic [15:0]       frame_cnt,
`endif
    fft_frame_tx_if.master    axis
);
    localparam int unsigned       N        = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(N - 1);

    typedef enum logic [1:0] {IDLE, CFG, DATA, DONE} state_t;

    state_t            state, state_nxt;
    logic              busy_nxt, done_nxt;
    logic [CFG_W-1:0]  cfg_q, cfg_q_nxt;
    logic              cfg_v, cfg_v_nxt;
    logic [DATA_W-1:0] tx_d, tx_d_nxt;
    logic              tx_v, tx_v_nxt;
    logic              tx_l, tx_l_nxt;
    logic [N_LOG2-1:0] idx, idx_nxt, idx_inc;
    logic [DATA_W-1:0] sample_buf [N];

    assign idx_inc = idx + N_LOG2'(1);

    // Host writes are blocked for the whole frame so the stream always reflects the buffer at start.
    always_ff @(posedge aclk) begin
        if (wr_en && !busy) sample_buf[wr_addr] <= wr_data;
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = done;
        cfg_q_nxt = cfg_q;
        cfg_v_nxt = cfg_v;
        tx_d_nxt  = tx_d;
        tx_v_nxt  = tx_v;
        tx_l_nxt  = tx_l;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    cfg_q_nxt = cfg_word;
                    cfg_v_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = CFG;
                end
            end
            CFG: begin
                if (axis.config_ready) begin
                    cfg_v_nxt = 1'b0;
                    tx_d_nxt  = sample_buf[0];
                    tx_v_nxt  = 1'b1;
                    tx_l_nxt  = (N == 1);
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tx_v && axis.tx_ready) begin
                    if (tx_l) begin
                        tx_v_nxt  = 1'b0;
                        tx_l_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt  = idx_inc;
                        tx_d_nxt = sample_buf[idx_inc];
                        tx_l_nxt = (idx_inc == LAST_IDX);
                    end
                end
            end
            DONE: begin
                done_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cfg_q <= '0;
            cfg_v <= 1'b0;
            tx_d  <= '0;
            tx_v  <= 1'b0;
            tx_l  <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            cfg_q <= cfg_q_nxt;
            cfg_v <= cfg_v_nxt;
            tx_d  <= tx_d_nxt;
            tx_v  <= tx_v_nxt;
            tx_l  <= tx_l_nxt;
            idx   <= idx_nxt;
        end
    end

`ifdef FFT_FRAME_TX_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  frame_cnt <= '0;
        else if (done) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

    assign axis.config_data  = cfg_q;
    assign axis.config_valid = cfg_v;
    assign axis.tx_data      = tx_d;
    assign axis.tx_valid     = tx_v;
    assign axis.tx_last      = tx_l;
endmodule
